flatten_chw_reorder: RTL

//  Sink for the flatten stream (valid/data/idx/frame_done). Buffers one full HWC-interleaved

---
 rtl/cnn_pkg.sv | 17 +
 rtl/flat_skid_buf.sv | 53 +++++
 rtl/flatten_chw_reorder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the flatten / FC boundary.
package cnn_pkg;

  localparam int unsigned FM_W   = 14;
  localparam int unsigned FM_H   = 14;
  localparam int unsigned FM_C   = 16;
  localparam int unsigned DW     = 8;
  localparam int unsigned AW     = 12;
  localparam int unsigned FLAT_N = FM_W * FM_H * FM_C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } flat_state_e;

endpackage

// File: rtl/flat_skid_buf.sv
// Two-entry valid/ready skid register; the head entry drives the outputs directly.
module flat_skid_buf #(
  parameter int unsigned WIDTH = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       fill_c
);

  logic [WIDTH-1:0] tail_q;
  logic             tail_v;
  logic             pop_c;

  assign pop_c  = out_valid && out_ready;
  assign fill_c = {out_valid & tail_v, out_valid ^ tail_v};

  // Producer guarantees room, so a push into a full, stalled buffer never happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      tail_v    <= 1'b0;
      tail_q    <= '0;
    end else if (!out_valid) begin
      if (in_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end
    end else if (!tail_v) begin
      if (pop_c && in_valid) begin
        out_data <= in_data;
      end else if (pop_c) begin
        out_valid <= 1'b0;
      end else if (in_valid) begin
        tail_v <= 1'b1;
        tail_q <= in_data;
      end
    end else if (pop_c) begin
      out_data <= tail_q;
      if (in_valid) begin
        tail_q <= in_data;
      end else begin
        tail_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/flatten_chw_reorder.sv
// Buffers one HWC-interleaved frame and replays it channel-major (CHW) behind a valid/ready port.
module flatten_chw_reorder #(
  parameter int unsigned W  = cnn_pkg::FM_W,
  parameter int unsigned H  = cnn_pkg::FM_H,
  parameter int unsigned C  = cnn_pkg::FM_C,
  parameter int unsigned DW = cnn_pkg::DW,
  parameter int unsigned AW = cnn_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_idx,
  input  logic          in_frame_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          err
);
  import cnn_pkg::*;

  localparam int unsigned N     = W * H * C;
  localparam int unsigned PIX_N = W * H;
  localparam int unsigned BW    = DW + AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(PIX_N - 1);
  localparam logic [AW-1:0] CH_STEP  = AW'(C);

  flat_state_e state, state_nx;

  logic [DW-1:0] ram [N];
  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_addr, rd_ch, rd_pix, rd_cnt;
  logic          rd_all;
  logic          rd_pend;
  logic [AW-1:0] rd_idx_q;
  logic          rd_last_q;

  logic          acc_c, pop_c, room_c;
  logic          wr_en_c, rd_en_c, err_set_c;
  logic [2:0]    occ_c;
  logic [1:0]    fill_c;
  logic [BW-1:0] skid_q;

  assign acc_c  = en && in_valid;
  assign pop_c  = out_valid && out_ready;
  // Entries the buffer will hold next cycle if nothing new is issued now.
  assign occ_c  = 3'(fill_c) + 3'(rd_pend) - 3'(pop_c);
  assign room_c = (occ_c <= 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (acc_c && (in_idx == '0)) state_nx = ST_FILL;
      ST_FILL:  if (acc_c && in_frame_done) state_nx = ST_DRAIN;
      ST_DRAIN: if (pop_c && out_last) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en_c   = 1'b0;
    rd_en_c   = 1'b0;
    err_set_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (acc_c) begin
          wr_en_c   = (in_idx == '0);
          err_set_c = (in_idx != '0);
        end
      end
      ST_FILL: begin
        if (acc_c) begin
          wr_en_c   = (in_idx <= LAST_IDX);
          err_set_c = (in_idx != wr_cnt) || (in_frame_done && (wr_cnt != LAST_IDX));
        end
      end
      ST_DRAIN: begin
        err_set_c = acc_c;
        rd_en_c   = !rd_all && room_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      ram[in_idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_c) begin
      rd_data_q <= ram[rd_addr];
    end
  end

  // Write count, CHW address walk (stride C within a channel), read pipeline tags, flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_addr   <= '0;
      rd_ch     <= '0;
      rd_pix    <= '0;
      rd_cnt    <= '0;
      rd_all    <= 1'b0;
      rd_pend   <= 1'b0;
      rd_idx_q  <= '0;
      rd_last_q <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_pend <= rd_en_c;
      busy    <= (state_nx != ST_IDLE);
      err     <= err | err_set_c;

      if (state == ST_IDLE) begin
        wr_cnt <= AW'(wr_en_c);
      end else if ((state == ST_FILL) && acc_c) begin
        wr_cnt <= wr_cnt + AW'(1);
      end

      if (state != ST_DRAIN) begin
        rd_addr <= '0;
        rd_ch   <= '0;
        rd_pix  <= '0;
        rd_cnt  <= '0;
        rd_all  <= 1'b0;
      end else if (rd_en_c) begin
        if (rd_pix == LAST_PIX) begin
          rd_pix  <= '0;
          rd_ch   <= rd_ch + AW'(1);
          rd_addr <= rd_ch + AW'(1);
        end else begin
          rd_pix  <= rd_pix + AW'(1);
          rd_addr <= rd_addr + CH_STEP;
        end
        if (rd_cnt == LAST_IDX) begin
          rd_all <= 1'b1;
        end else begin
          rd_cnt <= rd_cnt + AW'(1);
        end
      end

      if (rd_en_c) begin
        rd_idx_q  <= rd_cnt;
        rd_last_q <= (rd_cnt == LAST_IDX);
      end
    end
  end

  flat_skid_buf #(.WIDTH(BW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pend),
    .in_data   ({rd_last_q, rd_idx_q, rd_data_q}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_q),
    .fill_c    (fill_c)
  );

  assign {out_last, out_idx, out_data} = skid_q;

endmodule
